apu_aout_sequencer: RTL and testbench
=====================================

// Module: apu_aout_sequencer
// PURPOSE
// - Sits between the audio sample async FIFO (read side) and the PWM audio output stage (apu_aout).
// - Sequences enable/disable of the output stage and applies a linear gain ramp on start/stop to suppress pops.
// - Prefetches samples so one is always valid at sample_rdy; repeats the last sample on FIFO underrun and counts underruns.
// PARAMETERS
// - GAIN_STEP   default 1  gain change per consumed sample; power of two, 1..256 (ramp = 256/GAIN_STEP samples)
// - UNDER_W     default 8  width of saturating underrun counter
// PORTS
// - clk               in   1        system clock
// - rst_n             in   1        async active-low reset
// - cfg_en            in   1        level: 1 = play, 0 = ramp down and stop
// - cfg_repeat_interval in 8       repeat interval for output stage, 1/4-cycle units
// - underrun_clr      in   1        pulse: clear underrun counter
// - fifo_rdata        in   32       show-ahead FIFO head; {L[15:0], R[15:0]}, signed two's complement
// - fifo_rempty       in   1        FIFO empty
// - fifo_ren          out  1        pop FIFO head this cycle
// - aout_en           out  1        enable to output stage
// - aout_repeat_interval out 8     repeat interval to output stage
// - aout_sample       out  32       gain-scaled sample to output stage
// - aout_sample_rdy   in   1        output stage consumes aout_sample this cycle
// - status_running    out  1        1 in any state except IDLE
// - status_ramping    out  1        1 in RAMP_UP or RAMP_DOWN
// - status_underruns  out  UNDER_W  saturating underrun count
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low. All outputs registered except fifo_ren.
// - Reset values: state IDLE, gain 0, cur 0, aout_sample 0, aout_en 0, aout_repeat_interval 0, counter 0, fifo_ren 0.
// - States: IDLE, RAMP_UP, RUN, RAMP_DOWN (2-bit encoding).
// - IDLE: aout_en 0, fifo_ren 0, gain 0, cur 0. aout_repeat_interval <= cfg_repeat_interval every cycle.
//   On cfg_en=1 -> RAMP_UP; aout_en 1 from the next cycle.
// - Outside IDLE: aout_repeat_interval frozen; cfg_repeat_interval changes take effect only after returning to IDLE.
// - Consume event (aout_sample_rdy=1, state != IDLE):
//   - fifo_ren = !fifo_rempty, combinational, same cycle.
//   - If popped: cur <= fifo_rdata.
//   - Else: cur held (last sample repeated); status_underruns += 1, saturating at all-ones.
// - Gain update, applied only on consume events:
//   - RAMP_UP: gain += GAIN_STEP; at 256 -> RUN.
//   - RAMP_DOWN: gain -= GAIN_STEP; at 0 -> IDLE (aout_en 0 next cycle, cur cleared).
// - cfg_en=0 in RAMP_UP or RUN -> RAMP_DOWN immediately, from the current gain.
// - cfg_en=1 in RAMP_DOWN -> RAMP_UP immediately, from the current gain. No gain discontinuity on either reversal.
// - Scaling per channel: out = (s16 * {0,gain[8:0]}) >>> 8.
//   - Signed 16 x unsigned 9 -> 25-bit product; arithmetic shift (truncation toward -inf); keep bits [15:0].
//   - |out| <= |s16|, so no overflow. gain=256 is exact passthrough; gain=0 gives 0.
// - aout_sample is registered from cur and gain; it reflects a consume event 2 cycles later.
//   Output-stage sample spacing is far more than 2 cycles, so a valid sample is always presented at the next sample_rdy.
// - Latency: the first FIFO sample is popped at the first sample_rdy after start; audio before that point is 0.
// - underrun_clr coincident with an underrun: counter = 1.
// - aout_sample_rdy in IDLE is ignored (no pop, no count).
// - Async reset mid-operation: immediate return to IDLE values; no ramp down.
// STRUCTURE
// - Shared include apu_aout_defs.vh: state encodings, GAIN_ONE=9'd256, sample field positions (L=[31:16], R=[15:0]).
// - Sub-module apu_aout_gain: registered signed 16 x 9-bit scaler, one per channel (instantiated x2).
// - Top level: FSM, gain counter, prefetch register cur, underrun counter.
// TESTING
// - Start: FIFO preloaded with L=16'h4000, R=16'hC000, GAIN_STEP=1, cfg_en 0->1
//   -> aout_en=1; 256 consumes later state=RUN; aout_sample=32'h4000C000; samples monotonic during ramp.
// - Scale: gain=128, cur L=16'h8000, R=16'h0001 -> aout_sample L=16'hC000, R=16'h0000.
// - Underrun: fifo_rempty=1 at 3 consecutive sample_rdy in RUN
//   -> fifo_ren stays 0, aout_sample unchanged, status_underruns=3; pulse underrun_clr -> 0.
// - Saturation: 300 underruns -> status_underruns=8'hFF; coincident clr+underrun -> 1.
// - Reversal: cfg_en 1->0 at gain=100 -> RAMP_DOWN; cfg_en 0->1 at gain=60 -> RAMP_UP from 60;
//   full stop reaches IDLE with aout_en=0, aout_sample=0.
// - Config freeze/reset: change cfg_repeat_interval in RUN -> aout_repeat_interval unchanged until IDLE;
//   assert rst_n=0 mid-RAMP_UP -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/apu_aout_sequencer_pkg.sv
// Shared types and constants for the audio output sequencer: FSM state
// encoding, unity gain and the stereo sample field layout.
package apu_aout_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_e;

    // Unity gain: gain is a 9-bit unsigned value, 256 means passthrough.
    localparam logic [8:0] GAIN_ONE = 9'd256;

    // Stereo sample packing: {L[15:0], R[15:0]}.
    function automatic logic [15:0] sample_l(input logic [31:0] s);
        return s[31:16];
    endfunction

    function automatic logic [15:0] sample_r(input logic [31:0] s);
        return s[15:0];
    endfunction

endpackage

// File: rtl/apu_aout_sequencer_if.sv
// Bundles the FIFO read side and the PWM output-stage side of the sequencer.
// master = sequencer, slave = the FIFO plus output stage around it.
interface apu_aout_sequencer_if;

    logic [31:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_ren;
    logic        aout_en;
    logic [7:0]  aout_repeat_interval;
    logic [31:0] aout_sample;
    logic        aout_sample_rdy;

    modport master (
        input  fifo_rdata, fifo_rempty, aout_sample_rdy,
        output fifo_ren, aout_en, aout_repeat_interval, aout_sample
    );

    modport slave (
        output fifo_rdata, fifo_rempty, aout_sample_rdy,
        input  fifo_ren, aout_en, aout_repeat_interval, aout_sample
    );

endinterface

// File: rtl/apu_aout_sequencer_gain.sv
// Registered single-channel scaler: signed 16-bit sample times unsigned
// 9-bit gain, divided by 256 with an arithmetic shift (rounds toward -inf).
module apu_aout_sequencer_gain (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_i,
    input  logic [8:0]  gain_i,
    output logic [15:0] scaled_o
);

    // |sample * gain| <= 2^23, so the exact product fits a 24-bit signed value.
    logic signed [23:0] product;
    logic [15:0]        scaled_d;
    logic [15:0]        scaled_q;

    assign product  = $signed(sample_i) * $signed({1'b0, gain_i});
    assign scaled_d = 16'(product >>> 8);

    // Output register for the scaled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            scaled_q <= scaled_d;
        end
    end

    assign scaled_o = scaled_q;

endmodule

// File: rtl/apu_aout_sequencer.sv
// Audio output sequencer: start/stop ramps the gain linearly to avoid pops,
// prefetches one sample from the FIFO per output-stage consume, repeats the
// last sample on underrun and keeps a saturating underrun count.
module apu_aout_sequencer
    import apu_aout_sequencer_pkg::*;
#(
    parameter int GAIN_STEP = 1,   // power of two, 1..256
    parameter int UNDER_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic [7:0]           cfg_repeat_interval,
    input  logic                 underrun_clr,
    apu_aout_sequencer_if.master aout_if,
    output logic                 status_running,
    output logic                 status_ramping,
    output logic [UNDER_W-1:0]   status_underruns
);

    localparam logic [8:0] STEP = 9'(GAIN_STEP);

    state_e             state_q, state_d;
    logic [8:0]         gain_q, gain_d;
    logic [31:0]        cur_q, cur_d;
    logic [UNDER_W-1:0] under_q, under_d;
    logic               aout_en_q;
    logic [7:0]         rep_q;

    logic consume;
    logic pop;
    logic underrun;

    // The output stage only consumes while the sequencer is active.
    assign consume  = aout_if.aout_sample_rdy && (state_q != ST_IDLE);
    assign pop      = consume && !aout_if.fifo_rempty;
    assign underrun = consume && aout_if.fifo_rempty;

    assign aout_if.fifo_ren = pop;

    // Next-state, gain ramp and prefetch register update.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        gain_d  = gain_q;
        cur_d   = pop ? aout_if.fifo_rdata : cur_q;

        case (state_q)
            ST_IDLE: begin
                gain_d = '0;
                cur_d  = '0;
                if (cfg_en) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                // Direction reversal keeps the current gain; ramping resumes on the next consume.
                if (!cfg_en) begin
                    state_d = ST_RAMP_DOWN;
                end else if (gain_q == GAIN_ONE) begin
                    state_d = ST_RUN;
                end else if (consume) begin
                    if (gain_q >= GAIN_ONE - STEP) begin
                        gain_d  = GAIN_ONE;
                        state_d = ST_RUN;
                    end else begin
                        gain_d = gain_q + STEP;
                    end
                end
            end
            ST_RUN: begin
                if (!cfg_en) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (cfg_en) begin
                    state_d = ST_RAMP_UP;
                end else if (gain_q == '0) begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                end else if (consume) begin
                    if (gain_q <= STEP) begin
                        gain_d  = '0;
                        state_d = ST_IDLE;
                        cur_d   = '0;
                    end else begin
                        gain_d = gain_q - STEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating underrun counter; a clear coinciding with an underrun leaves one count.
    always_comb begin
        under_d = under_q;
        if (underrun_clr) begin
            under_d = underrun ? UNDER_W'(1) : '0;
        end else if (underrun && (under_q != '1)) begin
            under_d = under_q + 1'b1;
        end
    end

    // State, gain, prefetch and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gain_q    <= '0;
            cur_q     <= '0;
            under_q   <= '0;
            aout_en_q <= 1'b0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            cur_q     <= cur_d;
            under_q   <= under_d;
            aout_en_q <= (state_d != ST_IDLE);
            // Repeat interval tracks the config only while idle, frozen while playing.
            if (state_q == ST_IDLE) rep_q <= cfg_repeat_interval;
        end
    end

    logic [15:0] out_l, out_r;

    apu_aout_sequencer_gain u_gain_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample_l(cur_q)),
        .gain_i   (gain_q),
        .scaled_o (out_l)
    );

    apu_aout_sequencer_gain u_gain_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_i (sample_r(cur_q)),
        .gain_i   (gain_q),
        .scaled_o (out_r)
    );

    assign aout_if.aout_sample          = {out_l, out_r};
    assign aout_if.aout_en              = aout_en_q;
    assign aout_if.aout_repeat_interval = rep_q;

    assign status_running   = (state_q != ST_IDLE);
    assign status_ramping   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign status_underruns = under_q;

endmodule

// File: tb/tb_apu_aout_sequencer.sv
// Directed bench for the audio output sequencer: start ramp, scaling,
// underrun counting and saturation, ramp reversal, config freeze, async reset.
module tb_apu_aout_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cfg_en;
    logic [7:0] cfg_repeat_interval;
    logic       underrun_clr;
    logic       status_running;
    logic       status_ramping;
    logic [7:0] status_underruns;

    apu_aout_sequencer_if ifc ();

    apu_aout_sequencer #(
        .GAIN_STEP (1),
        .UNDER_W   (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_en              (cfg_en),
        .cfg_repeat_interval (cfg_repeat_interval),
        .underrun_clr        (underrun_clr),
        .aout_if             (ifc),
        .status_running      (status_running),
        .status_ramping      (status_ramping),
        .status_underruns    (status_underruns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model.
    logic [31:0] fifo_mem [0:1023];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign ifc.fifo_rempty = (wr_ptr == rd_ptr);
    assign ifc.fifo_rdata  = fifo_mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (ifc.fifo_ren) rd_ptr <= rd_ptr + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[9:0]] = d;
            wr_ptr++;
        end
    endtask

    // One output-stage consume pulse; returns fifo_ren seen during it.
    // Returns after the scaled sample has been registered.
    task automatic consume(input logic clr, output logic ren);
        @(negedge clk);
        ifc.aout_sample_rdy = 1'b1;
        underrun_clr        = clr;
        #1 ren = ifc.fifo_ren;
        @(negedge clk);
        ifc.aout_sample_rdy = 1'b0;
        underrun_clr        = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ren;
        int   g;

        rst_n               = 1'b0;
        cfg_en              = 1'b0;
        cfg_repeat_interval = 8'h12;
        underrun_clr        = 1'b0;
        ifc.aout_sample_rdy = 1'b0;

        // Reset values
        #1;
        check("rst_aout_en", ifc.aout_en, 0);
        check("rst_sample", ifc.aout_sample, 32'h0);
        check("rst_rep", ifc.aout_repeat_interval, 8'h00);
        check("rst_running", status_running, 0);
        check("rst_underruns", status_underruns, 0);
        check("rst_ren", ifc.fifo_ren, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rep_tracks", ifc.aout_repeat_interval, 8'h12);
        check("idle_running", status_running, 0);

        // Start: ramp up 256 consumes, L=4000 R=C000 -> sample = {g*64, -g*64}
        push(32'h4000C000, 258);
        cfg_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("start_aout_en", ifc.aout_en, 1);
        check("start_ramping", status_ramping, 1);
        check("start_sample_zero", ifc.aout_sample, 32'h0);
        for (g = 1; g <= 256; g++) begin
            consume(1'b0, ren);
            if (g == 1) check("first_pop_ren", ren, 1);
            check($sformatf("ramp_up_g%0d", g), ifc.aout_sample,
                  {16'(g * 64), 16'(-g * 64)});
            if (g == 255) check("ramp_up_still_ramping", status_ramping, 1);
        end
        check("run_running", status_running, 1);
        check("run_not_ramping", status_ramping, 0);
        check("run_sample", ifc.aout_sample, 32'h4000C000);

        // Config freeze while running
        cfg_repeat_interval = 8'h34;
        consume(1'b0, ren);
        consume(1'b0, ren);
        check("run_rep_frozen", ifc.aout_repeat_interval, 8'h12);

        // Underrun: FIFO now empty
        for (int i = 0; i < 3; i++) begin
            consume(1'b0, ren);
            check($sformatf("underrun_ren_%0d", i), ren, 0);
            check($sformatf("underrun_sample_%0d", i), ifc.aout_sample, 32'h4000C000);
        end
        check("underrun_count3", status_underruns, 8'd3);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        #1 check("underrun_clr", status_underruns, 8'd0);

        // Saturation
        for (int i = 0; i < 300; i++) consume(1'b0, ren);
        check("underrun_sat", status_underruns, 8'hFF);
        consume(1'b1, ren);
        check("clr_plus_underrun", status_underruns, 8'd1);

        // Ramp down with L=8000 R=0001
        push(32'h80000001, 340);
        cfg_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("down_ramping", status_ramping, 1);
        for (g = 255; g >= 60; g--) begin
            consume(1'b0, ren);
            if (g == 128) check("scale_g128", ifc.aout_sample, 32'hC0000000);
        end
        check("down_g60", ifc.aout_sample, 32'hE2000000);

        // Reverse to ramp up from 60
        cfg_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rev_up_ramping", status_ramping, 1);
        check("rev_up_no_jump", ifc.aout_sample, 32'hE2000000);
        consume(1'b0, ren);
        check("rev_up_g61", ifc.aout_sample, 32'hE1800000);
        for (g = 62; g <= 100; g++) consume(1'b0, ren);
        check("up_g100", ifc.aout_sample, 32'hCE000000);

        // Reverse down again and stop
        cfg_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        consume(1'b0, ren);
        check("rev_down_g99", ifc.aout_sample, 32'hCE800000);
        for (g = 98; g >= 1; g--) consume(1'b0, ren);
        check("down_g1_running", status_running, 1);
        consume(1'b0, ren);
        check("stop_running", status_running, 0);
        check("stop_aout_en", ifc.aout_en, 0);
        check("stop_sample", ifc.aout_sample, 32'h0);
        check("stop_rep_updated", ifc.aout_repeat_interval, 8'h34);

        // Consume in IDLE is ignored
        consume(1'b0, ren);
        check("idle_consume_ren", ren, 0);
        check("idle_consume_underruns", status_underruns, 8'd1);

        // Async reset mid ramp-up
        cfg_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) consume(1'b0, ren);
        check("pre_reset_g3", ifc.aout_sample, 32'hFE800000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_aout_en", ifc.aout_en, 0);
        check("async_rst_sample", ifc.aout_sample, 32'h0);
        check("async_rst_rep", ifc.aout_repeat_interval, 8'h00);
        check("async_rst_running", status_running, 0);
        check("async_rst_underruns", status_underruns, 8'd0);
        cfg_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
